esn7e_demo_ram_stream_loader: RTL and testbench
===============================================

// Module: esn7e_demo_ram_stream_loader
// PURPOSE
//  Upstream feeder for the Nios II instruction/data on-chip RAM. It takes a byte stream (host/UART/JTAG),
//  parses a 4-byte header, packs payload bytes into little-endian 32-bit words, and issues single-cycle
//  writes on the RAM's s1-style port. Used to load program/data images without going through the CPU.
// PARAMETERS
//  ADDR_W   16     RAM word-address width; drives ram_address.
//  DEPTH    51200  Valid RAM words; a write at word address >= DEPTH is dropped and sets err_range.
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   asynchronous active-low reset
//  in_valid        in   1   stream byte valid
//  in_data         in   8   stream byte
//  in_ready        out  1   loader accepts in_data this cycle (transfer = in_valid & in_ready)
//  reset_req       in   1   RAM reset request; while high the RAM is not clocked, so the loader stalls
//  ram_address     out  ADDR_W  RAM word address
//  ram_byteenable  out  4   lane enables, bit i = writedata[8i+7:8i]
//  ram_chipselect  out  1   high only in the write cycle
//  ram_write       out  1   high only in the write cycle
//  ram_writedata   out  32  packed word
//  ram_clken       out  1   constant 1
//  busy            out  1   high from first header byte accepted until DONE is reached
//  done            out  1   one-cycle pulse when a transfer completes
//  err_range       out  1   sticky; cleared at the next header start
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; ram_address=0, byteenable=0, chipselect=0, write=0, writedata=0;
//   busy=0, done=0, err_range=0 (and err_chk=0 when present). Reset mid-transfer abandons it; nothing is written.
//  Header, little-endian: bytes 0-1 = start word address A, bytes 2-3 = payload byte count N.
//  States:
//   IDLE: on the first transfer -> HDR; byte 0 is captured, busy=1, err flags cleared.
//   HDR: after byte 3 -> DATA, or -> FIN if N==0.
//   DATA: each byte goes into lane k (k = bytes so far mod 4). Once lane 3 is filled, or the last of the N
//    bytes arrives, -> WR. Lanes not filled get byteenable=0 and writedata=0.
//   WR: exactly one cycle with chipselect=write=1 at address A+w (w = word index, modulo 2^ADDR_W, wraps).
//    in_ready=0 in WR. If A+w >= DEPTH the write is suppressed (chipselect=write=0) and err_range is set.
//    Next state is DATA if bytes remain, else FIN.
//   FIN: one cycle with done=1 and busy=0 -> IDLE.
//  Latency: the write cycle is the cycle after the byte that completes the word is accepted.
//  reset_req high: in_ready=0 and the FSM holds in place. A pending WR keeps its outputs steady but
//   chipselect/write are forced to 0, and the write retires in the first cycle reset_req is low.
//  in_valid low in any state: hold, no timeout. Bytes arriving while in_ready=0 are not consumed.
//  Throughput: at most 4 bytes per 5 cycles.
// CONFIGURATION
//  ESN_LOADER_CHECKSUM_EN defined:
//   - After the N payload bytes, one extra byte C is accepted in state CHK, then -> FIN.
//   - If C != XOR of all header and payload bytes, err_chk (out, 1, sticky, cleared at next header)
//     is set. Already-written words are not rolled back.
//  ESN_LOADER_CHECKSUM_EN undefined: no CHK state, no err_chk port, and FIN follows the last write directly.
// TESTING
//  1 Header A=0x0010, N=8, bytes 11..88 -> two writes: @0x0010 0x44332211 be=F, @0x0011 0x88776655 be=F; done pulse.
//  2 A=0x0020, N=5, bytes AA BB CC DD EE -> @0x0020 0xDDCCBBAA be=F, then @0x0021 0x000000EE be=1.
//  3 N=0 -> no ram_write ever; done pulses 1 cycle after header byte 3; busy drops.
//  4 A=0xC7FF, N=8 -> word at 0xC7FF written; the 0xC800 write is suppressed and err_range=1 at done.
//  5 reset_req held for 3 cycles during WR -> write is delayed 3 cycles, data unchanged, in_ready=0 throughout.
//  6 reset_n low between payload bytes -> all outputs return to reset values; the next header starts clean.
//    With CHECKSUM_EN: a wrong C byte -> err_chk=1, and the words are still written.

Source files
------------

// File: rtl/esn7e_demo_ram_stream_loader_if.sv
// Stream-in / RAM-write bundle for the stream loader; "master" is the loader side,
// "slave" is the environment (byte source plus RAM s1 port).
interface esn7e_demo_ram_stream_loader_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [3:0]        ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [31:0]       ram_writedata;
  logic              ram_clken;

  modport master (
    input  in_valid, in_data,
    output in_ready,
    output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready,
    input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken
  );
endinterface

// File: rtl/esn7e_demo_ram_stream_loader.sv
// Byte-stream to on-chip RAM loader: 4-byte LE header (addr, count), LE word packing, one write cycle per word.
// Optional trailing XOR checksum byte and err_chk port under `ESN_LOADER_CHECKSUM_EN.
module esn7e_demo_ram_stream_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 51200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic reset_req,
  esn7e_demo_ram_stream_loader_if.master bus,
  output logic busy,
  output logic done,
  output logic err_range
`ifdef ESN_LOADER_CHECKSUM_EN
  ,
  output logic err_chk
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
  localparam logic [2:0] S_CHK  = 3'd5;

`ifdef ESN_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_TAIL = S_CHK;
`else
  localparam logic [2:0] S_TAIL = S_FIN;
`endif

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic [2:0]        r_state;
  logic [1:0]        r_hdr_cnt;
  logic [7:0]        r_hdr_lo;
  logic [15:0]       r_remain;
  logic [1:0]        r_lane;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_err_range;
`ifdef ESN_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
  logic              r_err_chk;
`endif

  logic              w_rdy;
  logic              w_xfer;
  logic              w_in_range;
  logic              w_wr_go;
  logic [15:0]       w_hdr_word;

  // Bytes are refused while writing, finishing, or while the RAM is held in reset.
  assign w_rdy      = ~reset_req && (r_state != S_WR) && (r_state != S_FIN);
  assign w_xfer     = bus.in_valid && w_rdy;
  assign w_in_range = (32'(r_addr) < 32'(DEPTH));
  assign w_wr_go    = (r_state == S_WR) && ~reset_req;
  assign w_hdr_word = {bus.in_data, r_hdr_lo};

  assign bus.in_ready       = w_rdy;
  assign bus.ram_address    = r_addr;
  assign bus.ram_byteenable = r_be;
  assign bus.ram_writedata  = r_wdata;
  assign bus.ram_chipselect = w_wr_go && w_in_range;
  assign bus.ram_write      = w_wr_go && w_in_range;
  assign bus.ram_clken      = 1'b1;

  assign busy      = (r_state == S_HDR) || (r_state == S_DATA) ||
                     (r_state == S_WR)  || (r_state == S_CHK);
  assign done      = (r_state == S_FIN) && ~reset_req;
  assign err_range = r_err_range;
`ifdef ESN_LOADER_CHECKSUM_EN
  assign err_chk   = r_err_chk;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_hdr_cnt   <= 2'd0;
      r_hdr_lo    <= 8'd0;
      r_remain    <= 16'd0;
      r_lane      <= 2'd0;
      r_addr      <= '0;
      r_be        <= 4'd0;
      r_wdata     <= 32'd0;
      r_err_range <= 1'b0;
`ifdef ESN_LOADER_CHECKSUM_EN
      r_xor       <= 8'd0;
      r_err_chk   <= 1'b0;
`endif
    end else begin
`ifdef ESN_LOADER_CHECKSUM_EN
      if (w_xfer) begin
        r_xor <= (r_state == S_IDLE) ? bus.in_data : (r_xor ^ bus.in_data);
      end
`endif
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_hdr_lo    <= bus.in_data;
            r_hdr_cnt   <= 2'd1;
            r_lane      <= 2'd0;
            r_be        <= 4'd0;
            r_wdata     <= 32'd0;
            r_err_range <= 1'b0;
`ifdef ESN_LOADER_CHECKSUM_EN
            r_err_chk   <= 1'b0;
`endif
            r_state     <= S_HDR;
          end
        end

        S_HDR: begin
          if (w_xfer) begin
            r_hdr_cnt <= r_hdr_cnt + 2'd1;
            case (r_hdr_cnt)
              2'd1: r_addr   <= ADDR_W'(w_hdr_word);
              2'd2: r_hdr_lo <= bus.in_data;
              2'd3: begin
                r_remain <= w_hdr_word;
                r_state  <= (w_hdr_word == 16'd0) ? S_TAIL : S_DATA;
              end
              default: ;
            endcase
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            r_wdata[{r_lane, 3'b000} +: 8] <= bus.in_data;
            r_be[r_lane] <= 1'b1;
            r_lane       <= r_lane + 2'd1;
            r_remain     <= r_remain - 16'd1;
            if ((r_lane == 2'd3) || (r_remain == 16'd1)) begin
              r_state <= S_WR;
            end
          end
        end

        S_WR: begin
          // Retires only when the RAM is clocked; outputs stay frozen meanwhile.
          if (!reset_req) begin
            if (!w_in_range) begin
              r_err_range <= 1'b1;
            end
            r_addr  <= r_addr + ADDR_ONE;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_state <= (r_remain != 16'd0) ? S_DATA : S_TAIL;
          end
        end

`ifdef ESN_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            if (bus.in_data != r_xor) begin
              r_err_chk <= 1'b1;
            end
            r_state <= S_FIN;
          end
        end
`endif

        S_FIN: begin
          if (!reset_req) begin
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_esn7e_demo_ram_stream_loader.sv
// Directed bench for the stream loader: header parsing, word packing, range drop, reset_req stall, mid-transfer reset.
module tb_esn7e_demo_ram_stream_loader;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 51200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic reset_req = 1'b0;
  logic busy, done, err_range;
`ifdef ESN_LOADER_CHECKSUM_EN
  logic err_chk;
`endif

  esn7e_demo_ram_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

  esn7e_demo_ram_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .reset_req (reset_req),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err_range (err_range)
`ifdef ESN_LOADER_CHECKSUM_EN
    ,
    .err_chk   (err_chk)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] tb_xor = 8'd0;

  logic [31:0] wa [64];
  logic [31:0] wd [64];
  logic [31:0] wb [64];
  int wr_n = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ram_write === 1'b1 && bus.ram_chipselect === 1'b1 && wr_n < 64) begin
      wa[wr_n] = 32'(bus.ram_address);
      wd[wr_n] = bus.ram_writedata;
      wb[wr_n] = 32'(bus.ram_byteenable);
      wr_n++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit hold_after);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!ok && n < 20) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    if (hold_after) reset_req = 1'b1;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    tb_xor = tb_xor ^ b;
  endtask

  task automatic send_hdr(input logic [15:0] a, input logic [15:0] n);
    tb_xor = 8'd0;
    send_byte(a[7:0], 1'b0);
    send_byte(a[15:8], 1'b0);
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
  endtask

  task automatic send_trailer();
`ifdef ESN_LOADER_CHECKSUM_EN
    send_byte(tb_xor, 1'b0);
`endif
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      n++;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},   32'(bus.in_ready), 32'd1);
    check({tag, "_addr"},  32'(bus.ram_address), 32'd0);
    check({tag, "_be"},    32'(bus.ram_byteenable), 32'd0);
    check({tag, "_cs"},    32'(bus.ram_chipselect), 32'd0);
    check({tag, "_wr"},    32'(bus.ram_write), 32'd0);
    check({tag, "_wdat"},  bus.ram_writedata, 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err_range), 32'd0);
    check({tag, "_clken"}, 32'(bus.ram_clken), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [7:0] t1 [8];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;

    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;

    // 1: two full words with latency check on the first write
    base = wr_n;
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_hdr(16'h0010, 16'd8);
    check("t1_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(t1[i], 1'b0);
    @(negedge clk);
    check("t1_lat_wr", 32'(bus.ram_write), 32'd1);
    check("t1_lat_rdy", 32'(bus.in_ready), 32'd0);
    check("t1_lat_addr", 32'(bus.ram_address), 32'h0010);
    for (int i = 4; i < 8; i++) send_byte(t1[i], 1'b0);
    send_trailer();
    wait_done("t1_done");
    check("t1_busy_fin", 32'(busy), 32'd0);
    check("t1_nwr", 32'(wr_n - base), 32'd2);
    check("t1_a0", wa[base], 32'h0010);
    check("t1_d0", wd[base], 32'h44332211);
    check("t1_b0", wb[base], 32'hF);
    check("t1_a1", wa[base+1], 32'h0011);
    check("t1_d1", wd[base+1], 32'h88776655);
    check("t1_b1", wb[base+1], 32'hF);

    // 2: partial trailing word
    base = wr_n;
    send_hdr(16'h0020, 16'd5);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'hEE, 1'b0);
    send_trailer();
    wait_done("t2_done");
    check("t2_nwr", 32'(wr_n - base), 32'd2);
    check("t2_a0", wa[base], 32'h0020);
    check("t2_d0", wd[base], 32'hDDCCBBAA);
    check("t2_b0", wb[base], 32'hF);
    check("t2_a1", wa[base+1], 32'h0021);
    check("t2_d1", wd[base+1], 32'h000000EE);
    check("t2_b1", wb[base+1], 32'h1);

    // 3: zero-length payload
    base = wr_n;
    send_hdr(16'h0030, 16'd0);
    send_trailer();
    @(negedge clk);
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t3_done_pulse", 32'(done), 32'd0);
    check("t3_nwr", 32'(wr_n - base), 32'd0);

    // 4: second word crosses DEPTH and is dropped
    base = wr_n;
    send_hdr(16'hC7FF, 16'd8);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    send_trailer();
    wait_done("t4_done");
    check("t4_err", 32'(err_range), 32'd1);
    check("t4_nwr", 32'(wr_n - base), 32'd1);
    check("t4_a0", wa[base], 32'hC7FF);
    check("t4_d0", wd[base], 32'h04030201);
    @(negedge clk);
    check("t4_err_sticky", 32'(err_range), 32'd1);

    // 5: reset_req stalls the write for three cycles
    base = wr_n;
    tb_xor = 8'd0;
    send_byte(8'h40, 1'b0);
    @(negedge clk);
    check("t5_err_clr", 32'(err_range), 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_hold_cs", 32'(bus.ram_chipselect), 32'd0);
      check("t5_hold_wr", 32'(bus.ram_write), 32'd0);
      check("t5_hold_rdy", 32'(bus.in_ready), 32'd0);
      check("t5_hold_addr", 32'(bus.ram_address), 32'h0040);
      check("t5_hold_dat", bus.ram_writedata, 32'hD4C3B2A1);
    end
    @(posedge clk);
    #1 reset_req = 1'b0;
    @(negedge clk);
    check("t5_wr", 32'(bus.ram_write), 32'd1);
    check("t5_dat", bus.ram_writedata, 32'hD4C3B2A1);
    send_trailer();
    wait_done("t5_done");
    check("t5_nwr", 32'(wr_n - base), 32'd1);

    // 6: reset between payload bytes, then a clean frame
    base = wr_n;
    send_hdr(16'h0050, 16'd8);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals("t6_rst");
    reset_n = 1'b1;
    send_hdr(16'h0060, 16'd4);
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b0);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_trailer();
    wait_done("t6_done");
    check("t6_nwr", 32'(wr_n - base), 32'd1);
    check("t6_a0", wa[base], 32'h0060);
    check("t6_d0", wd[base], 32'hF0DEBC9A);
    check("t6_b0", wb[base], 32'hF);

`ifdef ESN_LOADER_CHECKSUM_EN
    // 7: bad checksum flags err_chk, words still land
    base = wr_n;
    send_hdr(16'h0070, 16'd4);
    send_byte(8'h05, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(tb_xor ^ 8'hFF, 1'b0);
    wait_done("t7_done");
    check("t7_err_chk", 32'(err_chk), 32'd1);
    check("t7_nwr", 32'(wr_n - base), 32'd1);
    check("t7_d0", wd[base], 32'h08070605);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
